rsnn_run_controller: RTL and testbench

RSNN_RUN_CONTROLLER -- requirements
Module: rsnn_run_controller

---
 rtl/rsnn_pkg.sv | 23 ++
 rtl/rsnn_cycle_timer.sv | 27 ++
 rtl/rsnn_run_controller.sv | 156 +++++++++++++++
 tb/tb_rsnn_run_controller.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsnn_pkg.sv
// Shared definitions for the RSNN run controller: state encoding and defaults.
package rsnn_pkg;

  localparam int PARAM_BITS_DEF = 312;
  localparam int SYNC_LAT_DEF   = 2;

  localparam logic [3:0] S_IDLE        = 4'd0;
  localparam logic [3:0] S_LOAD_REQ    = 4'd1;
  localparam logic [3:0] S_LOAD_BIT    = 4'd2;
  localparam logic [3:0] S_LOAD_END    = 4'd3;
  localparam logic [3:0] S_STEP_WAIT   = 4'd4;
  localparam logic [3:0] S_STEP_LATCH  = 4'd5;
  localparam logic [3:0] S_STEP_EVAL   = 4'd6;
  localparam logic [3:0] S_STEP_SETTLE = 4'd7;
  localparam logic [3:0] S_DONE        = 4'd8;
  localparam logic [3:0] S_ERROR       = 4'd9;

  // True while a load or run is in progress (network side powered).
  function automatic logic is_active(input logic [3:0] s);
    return !((s == S_IDLE) || (s == S_DONE) || (s == S_ERROR));
  endfunction

endpackage

// File: rtl/rsnn_cycle_timer.sv
// Loadable down-counter shared by every timed wait of the run controller.
module rsnn_cycle_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Reload on request, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/rsnn_run_controller.sv
// Sequences a parameter load followed by num_steps network timesteps.
module rsnn_run_controller
  import rsnn_pkg::*;
#(
  parameter int PARAM_BITS  = PARAM_BITS_DEF,
  parameter int SYNC_LAT    = SYNC_LAT_DEF,
  parameter int EVAL_CYCLES = 1,
  parameter int TIMEOUT     = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] num_steps,
  input  logic       param_valid,
  input  logic       param_bit,
  output logic       param_ready,
  output logic       load_params,
  output logic       data_in,
  input  logic       data_written,
  input  logic       end_writing,
  input  logic       step_valid,
  input  logic [2:0] step_spikes,
  output logic       step_ready,
  output logic       system_enable,
  output logic       spike_input_reg_enable,
  output logic       RSNN_enable,
  output logic [2:0] input_spikes,
  input  logic [2:0] output_spikes,
  output logic       out_valid,
  output logic [2:0] out_spikes,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int BW = $clog2(PARAM_BITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [3:0]    state;
  logic [3:0]    state_nxt;
  logic [BW-1:0] bit_cnt;
  logic [7:0]    step_cnt;
  logic [7:0]    steps_lat;
  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          timer_zero;
  logic          bit_ack;
  logic          settle_end;
  logic          in_load;

  assign in_load    = (state == S_LOAD_BIT) || (state == S_LOAD_END);
  assign bit_ack    = (state == S_LOAD_BIT) && param_valid && data_written;
  assign settle_end = (state == S_STEP_SETTLE) && timer_zero;

  // Next-state decision; abort overrides everything except reset.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:        if (start) state_nxt = S_LOAD_REQ;
        S_LOAD_REQ:    state_nxt = S_LOAD_BIT;
        S_LOAD_BIT: begin
          if (bit_ack) begin
            if (bit_cnt == BW'(PARAM_BITS - 1)) state_nxt = S_LOAD_END;
          end else if (!data_written && timer_zero) begin
            state_nxt = S_ERROR;
          end
        end
        S_LOAD_END: begin
          if (end_writing) begin
            state_nxt = (steps_lat == 8'd0) ? S_DONE : S_STEP_WAIT;
          end else if (!data_written && timer_zero) begin
            state_nxt = S_ERROR;
          end
        end
        S_STEP_WAIT:   if (step_valid) state_nxt = S_STEP_LATCH;
        S_STEP_LATCH:  if (timer_zero) state_nxt = S_STEP_EVAL;
        S_STEP_EVAL:   if (timer_zero) state_nxt = S_STEP_SETTLE;
        S_STEP_SETTLE: begin
          if (timer_zero) begin
            state_nxt = (step_cnt + 8'd1 == steps_lat) ? S_DONE : S_STEP_WAIT;
          end
        end
        S_DONE:        state_nxt = S_IDLE;
        S_ERROR:       if (start) state_nxt = S_LOAD_REQ;
        default:       state_nxt = S_IDLE;
      endcase
    end
  end

  // Timer reload: on every state entry, and on every memory write while loading
  // so the timeout measures idle time since the last write.
  always_comb begin
    timer_load = (state_nxt != state) || (data_written && in_load);
    case (state_nxt)
      S_LOAD_BIT, S_LOAD_END:      timer_val = TW'(TIMEOUT - 1);
      S_STEP_LATCH, S_STEP_SETTLE: timer_val = TW'(SYNC_LAT);
      S_STEP_EVAL:                 timer_val = TW'(EVAL_CYCLES - 1);
      default:                     timer_val = '0;
    endcase
  end

  rsnn_cycle_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // State, counters and the registered spike/handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      bit_cnt      <= '0;
      step_cnt     <= '0;
      steps_lat    <= '0;
      input_spikes <= '0;
      out_spikes   <= '0;
      out_valid    <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      if (state_nxt == S_LOAD_REQ) steps_lat <= num_steps;
      if (state == S_LOAD_REQ) begin
        bit_cnt  <= '0;
        step_cnt <= '0;
      end else if (bit_ack) begin
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (!abort && (state == S_STEP_WAIT) && step_valid) input_spikes <= step_spikes;
      if (!abort && settle_end) begin
        out_spikes <= output_spikes;
        out_valid  <= 1'b1;
        step_cnt   <= step_cnt + 8'd1;
      end
    end
  end

  assign busy                   = is_active(state);
  assign system_enable          = busy;
  assign load_params            = (state == S_LOAD_REQ);
  assign data_in                = (state == S_LOAD_BIT) && param_valid && param_bit;
  assign param_ready            = bit_ack;
  assign step_ready             = (state == S_STEP_WAIT);
  assign spike_input_reg_enable = (state == S_STEP_LATCH);
  assign RSNN_enable            = (state == S_STEP_EVAL);
  assign done                   = (state == S_DONE);
  assign error                  = (state == S_ERROR);

endmodule

// File: tb/tb_rsnn_run_controller.sv
// Randomized and directed bench for rsnn_run_controller against a behavioural model.
module tb_rsnn_run_controller;

  localparam int PB = 312;
  localparam int SL = 2;
  localparam int EC = 1;
  localparam int TO = 1023;

  localparam int P_IDLE = 0, P_LOADREQ = 1, P_LOADBIT = 2, P_LOADEND = 3, P_WAIT = 4;
  localparam int P_LATCH = 5, P_EVAL = 6, P_SETTLE = 7, P_DONE = 8, P_ERR = 9;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [7:0] num_steps;
  logic       param_valid, param_bit, param_ready;
  logic       load_params, data_in, data_written, end_writing;
  logic       step_valid, step_ready;
  logic [2:0] step_spikes;
  logic       system_enable, spike_input_reg_enable, RSNN_enable;
  logic [2:0] input_spikes, output_spikes, out_spikes;
  logic       out_valid, busy, done, error;

  always #5 clk = ~clk;

  rsnn_run_controller #(
    .PARAM_BITS (PB), .SYNC_LAT (SL), .EVAL_CYCLES (EC), .TIMEOUT (TO)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .abort (abort), .num_steps (num_steps),
    .param_valid (param_valid), .param_bit (param_bit), .param_ready (param_ready),
    .load_params (load_params), .data_in (data_in), .data_written (data_written),
    .end_writing (end_writing), .step_valid (step_valid), .step_spikes (step_spikes),
    .step_ready (step_ready), .system_enable (system_enable),
    .spike_input_reg_enable (spike_input_reg_enable), .RSNN_enable (RSNN_enable),
    .input_spikes (input_spikes), .output_spikes (output_spikes), .out_valid (out_valid),
    .out_spikes (out_spikes), .busy (busy), .done (done), .error (error)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: phase plus elapsed/idle cycle counts, advanced on each clock.
  int m_ph = P_IDLE, m_bits = 0, m_idle = 0, m_el = 0, m_steps = 0, m_nsteps = 0;
  logic [2:0] m_in = '0, m_out = '0;
  logic m_ov = 1'b0;
  bit chk_en = 1'b0;

  function automatic void go(input int p);
    m_ph = p;
    m_idle = 0;
    m_el = 0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    m_ov = 1'b0;
    if (reset) begin
      go(P_IDLE);
      m_bits = 0; m_steps = 0; m_nsteps = 0; m_in = '0; m_out = '0;
      chk_en = 1'b1;
    end else if (abort) begin
      go(P_IDLE);
    end else begin
      case (m_ph)
        P_IDLE, P_ERR: if (start) begin m_nsteps = int'(num_steps); m_steps = 0; go(P_LOADREQ); end
        P_LOADREQ: begin m_bits = 0; go(P_LOADBIT); end
        P_LOADBIT: begin
          if (data_written) begin
            m_idle = 0;
            if (param_valid) begin
              m_bits++;
              if (m_bits == PB) go(P_LOADEND);
            end
          end else begin
            m_idle++;
            if (m_idle == TO) go(P_ERR);
          end
        end
        P_LOADEND: begin
          if (end_writing) go(m_nsteps == 0 ? P_DONE : P_WAIT);
          else if (data_written) m_idle = 0;
          else begin
            m_idle++;
            if (m_idle == TO) go(P_ERR);
          end
        end
        P_WAIT: if (step_valid) begin m_in = step_spikes; go(P_LATCH); end
        P_LATCH: begin m_el++; if (m_el == SL + 1) go(P_EVAL); end
        P_EVAL: begin m_el++; if (m_el == EC) go(P_SETTLE); end
        P_SETTLE: begin
          m_el++;
          if (m_el == SL + 1) begin
            m_out = output_spikes;
            m_ov = 1'b1;
            m_steps++;
            go(m_steps == m_nsteps ? P_DONE : P_WAIT);
          end
        end
        P_DONE: go(P_IDLE);
        default: go(P_IDLE);
      endcase
    end
  end

  // Event monitors used by the directed scenarios.
  int ov_cnt = 0, done_cnt = 0, sire_cnt = 0, rsnn_cnt = 0, pr_cnt = 0;
  int last_rsnn_cyc = 0, last_ov_cyc = 0;
  logic [2:0] last_out = '0;

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      bit act;
      act = !(m_ph == P_IDLE || m_ph == P_DONE || m_ph == P_ERR);
      chk("busy", 32'(busy), 32'(act));
      chk("system_enable", 32'(system_enable), 32'(act));
      chk("load_params", 32'(load_params), 32'(m_ph == P_LOADREQ));
      chk("data_in", 32'(data_in), 32'(m_ph == P_LOADBIT && param_valid && param_bit));
      chk("param_ready", 32'(param_ready), 32'(m_ph == P_LOADBIT && param_valid && data_written));
      chk("step_ready", 32'(step_ready), 32'(m_ph == P_WAIT));
      chk("spike_input_reg_enable", 32'(spike_input_reg_enable), 32'(m_ph == P_LATCH));
      chk("RSNN_enable", 32'(RSNN_enable), 32'(m_ph == P_EVAL));
      chk("done", 32'(done), 32'(m_ph == P_DONE));
      chk("error", 32'(error), 32'(m_ph == P_ERR));
      chk("input_spikes", 32'(input_spikes), 32'(m_in));
      chk("out_spikes", 32'(out_spikes), 32'(m_out));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      if (out_valid) begin ov_cnt++; last_out = out_spikes; last_ov_cyc = cyc; end
      if (done) done_cnt++;
      if (spike_input_reg_enable) sire_cnt++;
      if (RSNN_enable) begin rsnn_cnt++; last_rsnn_cyc = cyc; end
      if (param_ready) pr_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    start = 0; abort = 0; num_steps = '0; param_valid = 0; param_bit = 0;
    data_written = 0; end_writing = 0; step_valid = 0; step_spikes = '0;
  endtask

  task automatic do_start(input int n);
    clear_in();
    start = 1;
    num_steps = 8'(n);
    tick();
    start = 0;
  endtask

  // Full-rate parameter handshakes until nbits have been acknowledged.
  task automatic feed_bits(input int nbits);
    int got = 0;
    int guard = 0;
    while (got < nbits && guard < nbits + 20) begin
      param_valid = 1;
      param_bit = 1'($urandom % 2);
      data_written = (m_ph == P_LOADBIT);
      if (m_ph == P_LOADBIT) got++;
      tick();
      guard++;
    end
    param_valid = 0;
    data_written = 0;
    if (got < nbits) chk("feed_bits_bound", 32'(got), 32'(nbits));
  endtask

  task automatic wait_ph(input int p, input int limit);
    int n = 0;
    while (m_ph != p && n < limit) begin
      tick();
      n++;
    end
    if (m_ph != p) chk("wait_phase_bound", 32'(m_ph), 32'(p));
  endtask

  task automatic rand_cycles(input int n, input int abort_rate, input int start_rate);
    for (int i = 0; i < n; i++) begin
      start = ($urandom % start_rate) == 0;
      num_steps = 8'($urandom % 4);
      abort = (abort_rate != 0) && (($urandom % abort_rate) == 0);
      param_valid = ($urandom % 10) < 8;
      param_bit = 1'($urandom % 2);
      data_written = ($urandom % 10) < 7;
      end_writing = ($urandom % 4) == 0;
      step_valid = ($urandom % 3) == 0;
      step_spikes = 3'($urandom);
      output_spikes = 3'($urandom);
      tick();
    end
    clear_in();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    clear_in();
    output_spikes = '0;
    reset = 1;
    tick(); tick(); tick();
    reset = 0;
    tick();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_error", 32'(error), 0);
    chk("reset_out_spikes", 32'(out_spikes), 0);
    chk("reset_input_spikes", 32'(input_spikes), 0);

    // Load then two steps.
    ov_cnt = 0; done_cnt = 0; sire_cnt = 0; rsnn_cnt = 0;
    output_spikes = 3'b011;
    do_start(2);
    chk("load_params_pulse", 32'(load_params), 1);
    feed_bits(PB);
    end_writing = 1; tick(); end_writing = 0;
    wait_ph(P_WAIT, 5);
    step_valid = 1; step_spikes = 3'b101; tick(); step_valid = 0;
    chk("in_spikes_step1", 32'(input_spikes), 32'(3'b101));
    wait_ph(P_WAIT, 20);
    step_valid = 1; step_spikes = 3'b010; tick(); step_valid = 0;
    chk("in_spikes_step2", 32'(input_spikes), 32'(3'b010));
    wait_ph(P_IDLE, 20);
    tick();
    chk("two_step_out_valid_count", 32'(ov_cnt), 2);
    chk("two_step_out_spikes", 32'(last_out), 32'(3'b011));
    chk("two_step_done_count", 32'(done_cnt), 1);
    chk("two_step_busy_end", 32'(busy), 0);
    chk("latch_enable_cycles", 32'(sire_cnt), 6);
    chk("eval_enable_cycles", 32'(rsnn_cnt), 2);
    chk("eval_to_out_valid", 32'(last_ov_cyc - last_rsnn_cyc), 4);

    // Load only.
    done_cnt = 0; sire_cnt = 0; rsnn_cnt = 0;
    do_start(0);
    feed_bits(PB);
    end_writing = 1; tick(); end_writing = 0;
    chk("load_only_done", 32'(done), 1);
    tick();
    chk("load_only_done_one_cycle", 32'(done), 0);
    chk("load_only_done_count", 32'(done_cnt), 1);
    chk("load_only_no_latch", 32'(sire_cnt), 0);
    chk("load_only_no_eval", 32'(rsnn_cnt), 0);

    // Timeout after five bits.
    do_start(1);
    feed_bits(5);
    pr_cnt = 0;
    k = 0;
    while (!error && k < 2000) begin
      param_valid = 1'($urandom % 2);
      param_bit = 1'($urandom % 2);
      tick();
      k++;
    end
    param_valid = 0;
    chk("timeout_idle_cycles", 32'(k), 32'(TO));
    chk("timeout_param_ready_quiet", 32'(pr_cnt), 0);
    tick(); tick();
    chk("error_sticky", 32'(error), 1);
    do_start(1);
    chk("error_restart_load", 32'(load_params), 1);
    abort = 1; tick(); abort = 0;
    chk("abort_after_restart", 32'(busy), 0);

    // Abort together with start during evaluation.
    do_start(3);
    feed_bits(PB);
    end_writing = 1; tick(); end_writing = 0;
    wait_ph(P_WAIT, 5);
    step_valid = 1; step_spikes = 3'b110; tick(); step_valid = 0;
    wait_ph(P_EVAL, 10);
    chk("in_eval", 32'(RSNN_enable), 1);
    abort = 1; start = 1; num_steps = 8'd5;
    tick();
    clear_in();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_eval_off", 32'(RSNN_enable), 0);
    chk("abort_sys_off", 32'(system_enable), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_no_load", 32'(load_params), 0);

    // Reset mid-load at bit 100 beats every other input.
    do_start(2);
    feed_bits(100);
    reset = 1; start = 1; abort = 1; param_valid = 1; param_bit = 1;
    data_written = 1; end_writing = 1; step_valid = 1; step_spikes = 3'b111;
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_load_params", 32'(load_params), 0);
    chk("rst_data_in", 32'(data_in), 0);
    chk("rst_param_ready", 32'(param_ready), 0);
    chk("rst_input_spikes", 32'(input_spikes), 0);
    chk("rst_out_spikes", 32'(out_spikes), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_error", 32'(error), 0);
    clear_in();
    reset = 0;
    tick();
    do_start(2);
    chk("rst_restart_load_params", 32'(load_params), 1);
    feed_bits(PB);
    end_writing = 1; tick(); end_writing = 0;
    chk("rst_restart_full_load", 32'(step_ready), 1);
    abort = 1; tick(); abort = 0;

    // Randomized traffic, first without and then with occasional aborts.
    rand_cycles(8000, 0, 30);
    rand_cycles(6000, 2000, 30);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
